eob_mmio_monitor: RTL and testbench
===================================

EOB_MMIO_MONITOR -- requirements
Module: eob_mmio_monitor

Interface
REQ-001 SHALL have parameter AddrWidth, default 31, width of MMIO write-address channel.
REQ-002 SHALL have parameter CntWidth, default 32, width of cycle counter.
REQ-003 SHALL have parameter StopAddr, default 31'h0000_0000, MMIO address signalling end of benchmark.
REQ-004 SHALL have parameter MaxCycles, default 1_000_000, watchdog limit in RUN cycles.
REQ-005 SHALL have port clk_i, input, 1, sole clock, all state updates on rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port mmio_aw_addr_i, input, AddrWidth, MMIO write address from the memory top.
REQ-008 SHALL have port mmio_aw_valid_i, input, 1, MMIO write-address valid.
REQ-009 SHALL have port mmio_aw_addr_t0_i, input, AddrWidth, taint of mmio_aw_addr_i.
REQ-010 SHALL have port mmio_aw_valid_t0_i, input, 1, taint of mmio_aw_valid_i.
REQ-011 SHALL have port done_o, output, 1, sticky end-of-benchmark flag.
REQ-012 SHALL have port done_pulse_o, output, 1, single-cycle strobe on entry to DONE.
REQ-013 SHALL have port timeout_o, output, 1, sticky watchdog-expired flag.
REQ-014 SHALL have port cycles_o, output, CntWidth, RUN cycle count.
REQ-015 SHALL have port wr_cnt_o, output, 16, count of non-stop MMIO writes.
REQ-016 SHALL have port last_addr_o, output, AddrWidth, address of most recent non-stop MMIO write.
REQ-017 SHALL have port taint_seen_o, output, 1, sticky flag: tainted MMIO traffic observed.

Function
REQ-018 SHALL implement FSM states RUN, DONE, TIMEOUT; DONE and TIMEOUT are terminal until reset.
REQ-019 In RUN, cycles_o SHALL increment by 1 every cycle, including the cycle of the stop write; frozen in DONE/TIMEOUT.
REQ-020 In RUN, mmio_aw_valid_i=1 with mmio_aw_addr_i==StopAddr SHALL move FSM to DONE at next edge; done_o=1 from that edge onward.
REQ-021 done_pulse_o SHALL be 1 exactly in the first cycle in DONE, 0 otherwise.
REQ-022 In RUN, valid with address != StopAddr SHALL increment wr_cnt_o (saturating at 16'hFFFF) and load last_addr_o at next edge.
REQ-023 Stop write SHALL NOT change wr_cnt_o or last_addr_o.
REQ-024 In RUN, taint_seen_o SHALL set at next edge if mmio_aw_valid_t0_i=1, or mmio_aw_valid_i=1 and any bit of mmio_aw_addr_t0_i=1; never clears except by reset.
REQ-025 In DONE/TIMEOUT, all MMIO inputs SHALL be ignored; all outputs hold.
REQ-026 Latency from stop write to done_o SHALL be exactly 1 cycle; no ready/backpressure; every valid cycle is one accepted write.

Reset
REQ-027 While rst_i=1 at a clock edge: FSM<=RUN, cycles_o<=0, wr_cnt_o<=0, last_addr_o<=0, done_o<=0, done_pulse_o<=0, timeout_o<=0, taint_seen_o<=0.
REQ-028 Reset SHALL take priority over every other event, including mid-DONE/TIMEOUT and a simultaneous stop write.
REQ-029 First RUN cycle counted SHALL be the first edge with rst_i=0.

Configuration
REQ-030 Macro EOB_TIMEOUT_EN SHALL compile in the watchdog.
REQ-031 With EOB_TIMEOUT_EN defined: in RUN, when cycles_o==MaxCycles-1 and no stop write, next edge SHALL set cycles_o=MaxCycles, FSM=TIMEOUT, timeout_o=1.
REQ-032 With EOB_TIMEOUT_EN defined: a stop write in the cycle with cycles_o==MaxCycles-1 SHALL win: DONE, timeout_o=0.
REQ-033 Without EOB_TIMEOUT_EN: TIMEOUT state absent, timeout_o tied 0, MaxCycles unused, cycles_o saturates at all-ones.

Verification
REQ-034 Reset, idle 10 cycles, valid addr=StopAddr in cycle 11 -> next cycle done_o=1, done_pulse_o=1 for 1 cycle, cycles_o=11, wr_cnt_o=0.
REQ-035 Writes to 0x100, 0x104, 0x108 then stop -> wr_cnt_o=3, last_addr_o=0x108, done_o=1; further writes change nothing.
REQ-036 valid=1, addr_t0=31'h1 on a non-stop write -> taint_seen_o=1 next cycle, stays 1 through DONE; valid=0 with addr_t0 nonzero -> remains 0.
REQ-037 EOB_TIMEOUT_EN, MaxCycles=20, no stop -> timeout_o=1 with cycles_o=20 after 20 RUN cycles; stop at cycles_o=19 -> done_o=1, timeout_o=0.
REQ-038 rst_i=1 asserted while in DONE with wr_cnt_o=5 -> next cycle all outputs 0, FSM RUN; stop write coincident with rst_i=1 ignored.

Source files
------------

// File: rtl/eob_mmio_monitor.sv
// End-of-benchmark monitor: watches MMIO write-address traffic for a stop write, counts RUN
// cycles and writes, and tracks taint. Define EOB_TIMEOUT_EN to compile in the watchdog.
module eob_mmio_monitor #(
  parameter int unsigned          AddrWidth = 31,
  parameter int unsigned          CntWidth  = 32,
  parameter logic [AddrWidth-1:0] StopAddr  = 31'h0000_0000,
  parameter int unsigned          MaxCycles = 1_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] mmio_aw_addr_i,
  input  logic                 mmio_aw_valid_i,
  input  logic [AddrWidth-1:0] mmio_aw_addr_t0_i,
  input  logic                 mmio_aw_valid_t0_i,
  output logic                 done_o,
  output logic                 done_pulse_o,
  output logic                 timeout_o,
  output logic [CntWidth-1:0]  cycles_o,
  output logic [15:0]          wr_cnt_o,
  output logic [AddrWidth-1:0] last_addr_o,
  output logic                 taint_seen_o
);

  typedef enum logic [1:0] {
    StRun  = 2'd0,
`ifdef EOB_TIMEOUT_EN
    StDone = 2'd1,
    StTimeout = 2'd2
`else
    StDone = 2'd1
`endif
  } state_e;

  state_e               r_state;
  logic                 r_done;
  logic                 r_done_pulse;
  logic [CntWidth-1:0]  r_cycles;
  logic [15:0]          r_wr_cnt;
  logic [AddrWidth-1:0] r_last_addr;
  logic                 r_taint;

  logic                 w_stop;
  logic                 w_wr;
  logic                 w_taint;
  logic [CntWidth-1:0]  w_cycles_inc;
  logic [15:0]          w_wr_cnt_inc;

  assign w_stop       = mmio_aw_valid_i && (mmio_aw_addr_i == StopAddr);
  assign w_wr         = mmio_aw_valid_i && !w_stop;
  assign w_taint      = mmio_aw_valid_t0_i || (mmio_aw_valid_i && (|mmio_aw_addr_t0_i));
  // Both counters saturate rather than wrap.
  assign w_cycles_inc = (&r_cycles) ? r_cycles : r_cycles + CntWidth'(1);
  assign w_wr_cnt_inc = (&r_wr_cnt) ? r_wr_cnt : r_wr_cnt + 16'd1;

`ifdef EOB_TIMEOUT_EN
  logic w_limit;
  logic r_timeout;
  assign w_limit   = (r_cycles == CntWidth'(MaxCycles - 1));
  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StRun;
      r_done       <= 1'b0;
      r_done_pulse <= 1'b0;
      r_cycles     <= '0;
      r_wr_cnt     <= '0;
      r_last_addr  <= '0;
      r_taint      <= 1'b0;
`ifdef EOB_TIMEOUT_EN
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_done_pulse <= 1'b0;
      case (r_state)
        StRun: begin
          r_cycles <= w_cycles_inc;
          if (w_taint) begin
            r_taint <= 1'b1;
          end
          if (w_wr) begin
            r_wr_cnt    <= w_wr_cnt_inc;
            r_last_addr <= mmio_aw_addr_i;
          end
          // A stop write in the last allowed cycle beats the watchdog.
          if (w_stop) begin
            r_state      <= StDone;
            r_done       <= 1'b1;
            r_done_pulse <= 1'b1;
          end
`ifdef EOB_TIMEOUT_EN
          else if (w_limit) begin
            r_state   <= StTimeout;
            r_timeout <= 1'b1;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign done_o       = r_done;
  assign done_pulse_o = r_done_pulse;
  assign cycles_o     = r_cycles;
  assign wr_cnt_o     = r_wr_cnt;
  assign last_addr_o  = r_last_addr;
  assign taint_seen_o = r_taint;

endmodule

// File: tb/tb_eob_mmio_monitor.sv
// Scoreboard bench for eob_mmio_monitor: a reference model predicts every cycle's outputs,
// a separate monitor compares them. Watchdog scenarios run when EOB_TIMEOUT_EN is defined.
module tb_eob_mmio_monitor;

  localparam int unsigned AW       = 31;
  localparam int unsigned CW       = 8;
  localparam logic [30:0] STOP     = 31'h40;
  localparam int unsigned MAX_CYC  = 20;
  localparam int          CNT_MAX  = 255;
`ifdef EOB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [30:0]   addr_i = '0;
  logic          valid_i = 1'b0;
  logic [30:0]   addr_t0_i = '0;
  logic          valid_t0_i = 1'b0;
  logic          done_o, done_pulse_o, timeout_o, taint_seen_o;
  logic [7:0]    cycles_o;
  logic [15:0]   wr_cnt_o;
  logic [30:0]   last_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  eob_mmio_monitor #(
    .AddrWidth(AW),
    .CntWidth (CW),
    .StopAddr (STOP),
    .MaxCycles(MAX_CYC)
  ) u_dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .mmio_aw_addr_i    (addr_i),
    .mmio_aw_valid_i   (valid_i),
    .mmio_aw_addr_t0_i (addr_t0_i),
    .mmio_aw_valid_t0_i(valid_t0_i),
    .done_o            (done_o),
    .done_pulse_o      (done_pulse_o),
    .timeout_o         (timeout_o),
    .cycles_o          (cycles_o),
    .wr_cnt_o          (wr_cnt_o),
    .last_addr_o       (last_addr_o),
    .taint_seen_o      (taint_seen_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        done, pulse, to, taint;
    logic [7:0]  cyc;
    logic [15:0] wr;
    logic [30:0] last;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: "finished" means the benchmark ended one way or another.
  bit          m_done, m_pulse, m_to, m_taint;
  int          m_cyc, m_wr;
  logic [30:0] m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic model_step(input logic rst, input logic v, input logic [30:0] a,
                            input logic vt, input logic [30:0] at);
    if (rst) begin
      m_done = 0; m_pulse = 0; m_to = 0; m_taint = 0; m_cyc = 0; m_wr = 0; m_last = '0;
    end else begin
      m_pulse = 0;
      if (!m_done && !m_to) begin
        if (vt || (v && at != 0)) m_taint = 1;
        if (v && a != STOP) begin
          if (m_wr < 65535) m_wr++;
          m_last = a;
        end
        if (m_cyc < CNT_MAX) m_cyc++;
        if (v && a == STOP) begin
          m_done = 1; m_pulse = 1;
        end else if (TO_EN && m_cyc == int'(MAX_CYC)) begin
          m_to = 1;
        end
      end
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [30:0] a,
                       input logic vt, input logic [30:0] at);
    exp_t e;
    rst_i = rst; valid_i = v; addr_i = a; valid_t0_i = vt; addr_t0_i = at;
    model_step(rst, v, a, vt, at);
    e.done = m_done; e.pulse = m_pulse; e.to = m_to; e.taint = m_taint;
    e.cyc = 8'(m_cyc); e.wr = 16'(m_wr); e.last = m_last;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, 0, '0);
  endtask

  task automatic wr(input logic [30:0] a);
    drive(0, 1, a, 0, '0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("done_o",       32'(done_o),       32'(e.done));
      chk("done_pulse_o", 32'(done_pulse_o), 32'(e.pulse));
      chk("timeout_o",    32'(timeout_o),    32'(e.to));
      chk("taint_seen_o", 32'(taint_seen_o), 32'(e.taint));
      chk("cycles_o",     32'(cycles_o),     32'(e.cyc));
      chk("wr_cnt_o",     32'(wr_cnt_o),     32'(e.wr));
      chk("last_addr_o",  32'(last_addr_o),  32'(e.last));
    end
  end

  initial begin
    logic [30:0] a;
    @(negedge clk);

    // Idle 10 cycles, stop in cycle 11.
    drive(1, 0, '0, 0, '0);
    drive(1, 0, '0, 0, '0);
    idle(10);
    wr(STOP);
    chk("stop11_cycles", 32'(cycles_o), 32'd11);
    chk("stop11_pulse", 32'(done_pulse_o), 32'd1);
    chk("stop11_wr", 32'(wr_cnt_o), 32'd0);
    idle(1);
    chk("stop11_pulse_gone", 32'(done_pulse_o), 32'd0);
    chk("stop11_done_sticky", 32'(done_o), 32'd1);

    // Three writes then stop; later writes are ignored.
    drive(1, 0, '0, 0, '0);
    wr(31'h100); wr(31'h104); wr(31'h108); wr(STOP);
    wr(31'h200); drive(0, 1, 31'h300, 1, 31'h7); idle(2);
    chk("wr3_cnt", 32'(wr_cnt_o), 32'd3);
    chk("wr3_last", 32'(last_addr_o), 32'h108);
    chk("wr3_taint_ignored", 32'(taint_seen_o), 32'd0);

    // Taint on a valid write sticks through DONE; address taint without valid does not.
    drive(1, 0, '0, 0, '0);
    drive(0, 1, 31'h200, 0, 31'h1);
    chk("taint_set", 32'(taint_seen_o), 32'd1);
    wr(STOP); idle(2);
    chk("taint_through_done", 32'(taint_seen_o), 32'd1);
    drive(1, 0, '0, 0, '0);
    for (int i = 0; i < 4; i++) drive(0, 0, 31'h5a5, 0, 31'h7fff_ffff);
    chk("taint_no_valid", 32'(taint_seen_o), 32'd0);

    // Reset out of DONE with a coincident stop write.
    drive(1, 0, '0, 0, '0);
    for (int i = 0; i < 5; i++) wr(31'h10 + 31'(i));
    wr(STOP);
    chk("pre_rst_wr5", 32'(wr_cnt_o), 32'd5);
    drive(1, 1, STOP, 1, 31'h3);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_cycles", 32'(cycles_o), 32'd0);
    idle(1);
    chk("rst_first_run_cycle", 32'(cycles_o), 32'd1);

    if (TO_EN) begin
      drive(1, 0, '0, 0, '0);
      idle(20);
      chk("wd_timeout", 32'(timeout_o), 32'd1);
      chk("wd_cycles", 32'(cycles_o), 32'd20);
      idle(3);
      chk("wd_frozen", 32'(cycles_o), 32'd20);
      drive(1, 0, '0, 0, '0);
      idle(19);
      wr(STOP);
      chk("wd_stop_wins_done", 32'(done_o), 32'd1);
      chk("wd_stop_wins_to", 32'(timeout_o), 32'd0);
    end else begin
      drive(1, 0, '0, 0, '0);
      idle(260);
      chk("cyc_saturate", 32'(cycles_o), 32'd255);
    end

    // Randomised episodes.
    for (int ep = 0; ep < 40; ep++) begin
      drive(1, 0, '0, 0, '0);
      for (int c = 0; c < int'($urandom_range(40, 5)); c++) begin
        case ($urandom_range(4, 0))
          0: a = STOP;
          1: a = 31'h100;
          2: a = 31'h104;
          default: a = 31'($urandom);
        endcase
        if ($urandom_range(5, 0) != 0 && a == STOP) a = 31'h108;
        drive(($urandom_range(49, 0) == 0), ($urandom_range(2, 0) == 0), a,
              ($urandom_range(15, 0) == 0),
              ($urandom_range(15, 0) == 0) ? 31'($urandom) : 31'h0);
      end
    end

    idle(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
